// File: rtl/traffic_stats_pkg.sv
// Shared constants, FSM state type and saturating arithmetic for the
// per-window UDP traffic statistics block.
package traffic_stats_pkg;

  localparam logic [7:0] IP_PROTO_UDP = 8'd17;
  localparam int         LEN_W        = 16;
  localparam int         PORT_W       = 16;

  typedef enum logic {
    ACCUM   = 1'b0,
    PUBLISH = 1'b1
  } stats_state_e;

  // Adds a and b and clamps the result to the all-ones value of a w-bit field.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) begin
      sat_add = lim[63:0];
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/stats_window_timer.sv
// Free-running window timer; tc is a registered one-cycle pulse on the
// last cycle of every WINDOW_CYCLES-long window.
module stats_window_timer #(
  parameter int WINDOW_CYCLES = 125000000
) (
  input  logic clk125MHz,
  input  logic rst_n,
  output logic tc
);

  localparam int TW = $clog2(WINDOW_CYCLES);

  logic [TW-1:0] cnt_r;
  logic          tc_r;

  // Window counter; tc_r is raised one cycle early so it lines up with the terminal count.
  always_ff @(posedge clk125MHz) begin
    if (!rst_n) begin
      cnt_r <= '0;
      tc_r  <= 1'b0;
    end else begin
      if (cnt_r == TW'(WINDOW_CYCLES - 1)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + TW'(1);
      end
      tc_r <= (cnt_r == TW'(WINDOW_CYCLES - 2));
    end
  end

  assign tc = tc_r;

endmodule

// File: rtl/traffic_window_stats.sv
// Accumulates UDP packet statistics over fixed time windows and publishes
// one snapshot per window through a valid/ready output register.
module traffic_window_stats
  import traffic_stats_pkg::*;
#(
  parameter int WINDOW_CYCLES = 125000000,
  parameter int CNT_W         = 32,
  parameter int BYTE_W        = 48
) (
  input  logic              clk125MHz,
  input  logic              rst_n,
  input  logic              udp_hdr_valid,
  output logic              udp_hdr_ready,
  input  logic [15:0]       ip_length,
  input  logic [7:0]        ip_protocol,
  input  logic [15:0]       udp_source_port,
  input  logic [15:0]       udp_dest_port,
  input  logic [15:0]       watch_port,
  output logic              stats_valid,
  input  logic              stats_ready,
  output logic [CNT_W-1:0]  stats_pkt_count,
  output logic [BYTE_W-1:0] stats_byte_count,
  output logic [CNT_W-1:0]  stats_watch_count,
  output logic [15:0]       stats_min_len,
  output logic [15:0]       stats_max_len,
  output logic              stats_overflow
);

  logic              tc_s;
  logic              counted_s;
  logic              hit_s;
  logic              load_s;
  logic              drop_s;
  stats_state_e      state_r, state_nxt_s;
  logic [CNT_W-1:0]  pkt_r, pkt_nxt_s;
  logic [BYTE_W-1:0] byte_r, byte_nxt_s;
  logic [CNT_W-1:0]  watch_r, watch_nxt_s;
  logic [LEN_W-1:0]  min_r, min_nxt_s;
  logic [LEN_W-1:0]  max_r, max_nxt_s;
  logic              lost_r;

  stats_window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk125MHz (clk125MHz),
    .rst_n     (rst_n),
    .tc        (tc_s)
  );

  // Headers are never back-pressured: ready follows reset release directly.
  assign udp_hdr_ready = rst_n;
  assign stats_valid   = (state_r == PUBLISH);

  // Next accumulator values including the header (if any) of this cycle.
  always_comb begin
    counted_s   = udp_hdr_valid && rst_n && (ip_protocol == IP_PROTO_UDP);
    hit_s       = (udp_source_port == watch_port) || (udp_dest_port == watch_port);
    pkt_nxt_s   = pkt_r;
    byte_nxt_s  = byte_r;
    watch_nxt_s = watch_r;
    min_nxt_s   = min_r;
    max_nxt_s   = max_r;
    if (counted_s) begin
      pkt_nxt_s  = CNT_W'(sat_add(64'(pkt_r), 64'd1, CNT_W));
      byte_nxt_s = BYTE_W'(sat_add(64'(byte_r), 64'(ip_length), BYTE_W));
      if (hit_s) begin
        watch_nxt_s = CNT_W'(sat_add(64'(watch_r), 64'd1, CNT_W));
      end else begin
        watch_nxt_s = watch_r;
      end
      min_nxt_s = (ip_length < min_r) ? ip_length : min_r;
      max_nxt_s = (ip_length > max_r) ? ip_length : max_r;
    end else begin
      pkt_nxt_s = pkt_r;
    end
  end

  // Publish FSM: load a snapshot on TC when the output register is free, else drop it.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      ACCUM: begin
        if (tc_s) begin
          load_s      = 1'b1;
          state_nxt_s = PUBLISH;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      PUBLISH: begin
        if (stats_ready) begin
          if (tc_s) begin
            load_s      = 1'b1;
            state_nxt_s = PUBLISH;
          end else begin
            state_nxt_s = ACCUM;
          end
        end else begin
          drop_s      = tc_s;
          state_nxt_s = PUBLISH;
        end
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // Accumulators restart in the cycle after TC; the TC-cycle header lands in the snapshot.
  always_ff @(posedge clk125MHz) begin
    if (!rst_n) begin
      state_r <= ACCUM;
      pkt_r   <= '0;
      byte_r  <= '0;
      watch_r <= '0;
      min_r   <= 16'hFFFF;
      max_r   <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (tc_s) begin
        pkt_r   <= '0;
        byte_r  <= '0;
        watch_r <= '0;
        min_r   <= 16'hFFFF;
        max_r   <= 16'h0000;
      end else begin
        pkt_r   <= pkt_nxt_s;
        byte_r  <= byte_nxt_s;
        watch_r <= watch_nxt_s;
        min_r   <= min_nxt_s;
        max_r   <= max_nxt_s;
      end
    end
  end

  // Snapshot register and lost-window flag.
  always_ff @(posedge clk125MHz) begin
    if (!rst_n) begin
      stats_pkt_count   <= '0;
      stats_byte_count  <= '0;
      stats_watch_count <= '0;
      stats_min_len     <= 16'h0000;
      stats_max_len     <= 16'h0000;
      stats_overflow    <= 1'b0;
      lost_r            <= 1'b0;
    end else if (load_s) begin
      stats_pkt_count   <= pkt_nxt_s;
      stats_byte_count  <= byte_nxt_s;
      stats_watch_count <= watch_nxt_s;
      stats_min_len     <= (pkt_nxt_s == '0) ? 16'h0000 : min_nxt_s;
      stats_max_len     <= (pkt_nxt_s == '0) ? 16'h0000 : max_nxt_s;
      stats_overflow    <= lost_r;
      lost_r            <= 1'b0;
    end else if (drop_s) begin
      lost_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_window_stats.sv
// Directed bench for traffic_window_stats with WINDOW_CYCLES = 100; a second
// instance with CNT_W = 4 shares the stimulus to exercise counter saturation.
module tb_traffic_window_stats;

  logic        clk125MHz;
  logic        rst_n;
  logic        udp_hdr_valid;
  logic [15:0] ip_length;
  logic [7:0]  ip_protocol;
  logic [15:0] udp_source_port;
  logic [15:0] udp_dest_port;
  logic [15:0] watch_port;
  logic        stats_ready;

  logic        hdr_ready, sv;
  logic [31:0] pkt, wcnt;
  logic [47:0] bytes;
  logic [15:0] minl, maxl;
  logic        ovf;

  logic        hdr_ready2, sv2;
  logic [3:0]  pkt2, wcnt2;
  logic [47:0] bytes2;
  logic [15:0] minl2, maxl2;
  logic        ovf2;

  int cyc;
  int errors;
  int checks;

  traffic_window_stats #(.WINDOW_CYCLES(100), .CNT_W(32), .BYTE_W(48)) dut (
    .clk125MHz(clk125MHz), .rst_n(rst_n),
    .udp_hdr_valid(udp_hdr_valid), .udp_hdr_ready(hdr_ready),
    .ip_length(ip_length), .ip_protocol(ip_protocol),
    .udp_source_port(udp_source_port), .udp_dest_port(udp_dest_port),
    .watch_port(watch_port), .stats_valid(sv), .stats_ready(stats_ready),
    .stats_pkt_count(pkt), .stats_byte_count(bytes), .stats_watch_count(wcnt),
    .stats_min_len(minl), .stats_max_len(maxl), .stats_overflow(ovf)
  );

  traffic_window_stats #(.WINDOW_CYCLES(100), .CNT_W(4), .BYTE_W(48)) dut_sat (
    .clk125MHz(clk125MHz), .rst_n(rst_n),
    .udp_hdr_valid(udp_hdr_valid), .udp_hdr_ready(hdr_ready2),
    .ip_length(ip_length), .ip_protocol(ip_protocol),
    .udp_source_port(udp_source_port), .udp_dest_port(udp_dest_port),
    .watch_port(watch_port), .stats_valid(sv2), .stats_ready(stats_ready),
    .stats_pkt_count(pkt2), .stats_byte_count(bytes2), .stats_watch_count(wcnt2),
    .stats_min_len(minl2), .stats_max_len(maxl2), .stats_overflow(ovf2)
  );

  initial begin
    clk125MHz = 1'b0;
    forever #5 clk125MHz = ~clk125MHz;
  end

  task automatic step();
    @(posedge clk125MHz);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic hdr(input logic [15:0] len, input logic [7:0] proto,
                     input logic [15:0] spt, input logic [15:0] dpt);
    udp_hdr_valid   = 1'b1;
    ip_length       = len;
    ip_protocol     = proto;
    udp_source_port = spt;
    udp_dest_port   = dpt;
    step();
    udp_hdr_valid   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    cyc             = 0;
    rst_n           = 1'b0;
    udp_hdr_valid   = 1'b1;
    ip_length       = 16'd500;
    ip_protocol     = 8'd17;
    udp_source_port = 16'd53;
    udp_dest_port   = 16'd53;
    watch_port      = 16'd53;
    stats_ready     = 1'b1;

    // Reset with a valid header presented: nothing may be accepted.
    repeat (3) @(posedge clk125MHz);
    #3;
    check("rst_hdr_ready", 64'(hdr_ready), 64'd0);
    check("rst_valid",     64'(sv),        64'd0);
    check("rst_pkt",       64'(pkt),       64'd0);
    check("rst_bytes",     64'(bytes),     64'd0);
    check("rst_watch",     64'(wcnt),      64'd0);
    check("rst_min",       64'(minl),      64'd0);
    check("rst_max",       64'(maxl),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);

    rst_n         = 1'b1;
    udp_hdr_valid = 1'b0;
    cyc           = 0;
    #1;
    check("ready_after_rst", 64'(hdr_ready), 64'd1);

    // Window 1: three UDP headers, two on the watched port.
    goto_cyc(10); hdr(16'd60,   8'd17, 16'd1000, 16'd53);
    goto_cyc(20); hdr(16'd1500, 8'd17, 16'd1001, 16'd80);
    goto_cyc(30); hdr(16'd200,  8'd17, 16'd1002, 16'd53);
    goto_cyc(99); #2;
    check("w1_not_yet_valid", 64'(sv), 64'd0);
    goto_cyc(100); #2;
    check("w1_valid", 64'(sv),    64'd1);
    check("w1_pkt",   64'(pkt),   64'd3);
    check("w1_bytes", 64'(bytes), 64'd1760);
    check("w1_watch", 64'(wcnt),  64'd2);
    check("w1_min",   64'(minl),  64'd60);
    check("w1_max",   64'(maxl),  64'd1500);
    check("w1_ovf",   64'(ovf),   64'd0);
    goto_cyc(101); #2;
    check("w1_consumed", 64'(sv), 64'd0);

    // Window 2: only a TCP header, so the window is empty.
    goto_cyc(150); hdr(16'd700, 8'd6, 16'd53, 16'd53);
    goto_cyc(200); #2;
    check("w2_valid", 64'(sv),    64'd1);
    check("w2_pkt",   64'(pkt),   64'd0);
    check("w2_bytes", 64'(bytes), 64'd0);
    check("w2_watch", 64'(wcnt),  64'd0);
    check("w2_min",   64'(minl),  64'd0);
    check("w2_max",   64'(maxl),  64'd0);

    // Window 3: header on the terminal-count cycle belongs to the closing window.
    goto_cyc(299); hdr(16'd100, 8'd17, 16'd1000, 16'd80);
    goto_cyc(300); #2;
    check("w3_pkt",   64'(pkt),   64'd1);
    check("w3_bytes", 64'(bytes), 64'd100);
    check("w3_min",   64'(minl),  64'd100);
    check("w3_max",   64'(maxl),  64'd100);
    goto_cyc(400); #2;
    check("w4_pkt",   64'(pkt),   64'd0);
    check("w4_bytes", 64'(bytes), 64'd0);

    // Windows 5..8: consumer stalls across two TCs, one snapshot is dropped.
    goto_cyc(401); stats_ready = 1'b0;
    goto_cyc(450); hdr(16'd70, 8'd17, 16'd1000, 16'd53);
    goto_cyc(500); #2;
    check("w5_valid", 64'(sv),    64'd1);
    check("w5_bytes", 64'(bytes), 64'd70);
    check("w5_watch", 64'(wcnt),  64'd1);
    check("w5_ovf",   64'(ovf),   64'd0);
    goto_cyc(550); hdr(16'd300, 8'd17, 16'd1000, 16'd80);
    goto_cyc(600); #2;
    check("hold_valid", 64'(sv),    64'd1);
    check("hold_pkt",   64'(pkt),   64'd1);
    check("hold_bytes", 64'(bytes), 64'd70);
    check("hold_max",   64'(maxl),  64'd70);
    goto_cyc(610); stats_ready = 1'b1;
    step(); #2;
    check("hold_consumed", 64'(sv), 64'd0);
    goto_cyc(650); hdr(16'd80, 8'd17, 16'd1000, 16'd80);
    goto_cyc(700); #2;
    check("w7_valid", 64'(sv),    64'd1);
    check("w7_bytes", 64'(bytes), 64'd80);
    check("w7_ovf",   64'(ovf),   64'd1);
    goto_cyc(750); hdr(16'd90, 8'd17, 16'd1000, 16'd80);
    goto_cyc(800); #2;
    check("w8_bytes", 64'(bytes), 64'd90);
    check("w8_ovf",   64'(ovf),   64'd0);

    // Window 9: 20 headers; the CNT_W = 4 instance must saturate at 15.
    goto_cyc(801);
    for (int i = 0; i < 20; i++) hdr(16'd10, 8'd17, 16'd1000, 16'd53);
    goto_cyc(900); #2;
    check("sat_pkt4",   64'(pkt2),   64'd15);
    check("sat_watch4", 64'(wcnt2),  64'd15);
    check("sat_bytes4", 64'(bytes2), 64'd200);
    check("sat_pkt32",  64'(pkt),    64'd20);
    check("sat_bytes",  64'(bytes),  64'd200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
